// File: rtl/mioc_flop_bank_if.sv
// Handshake/bus bundle for mioc_flop_bank: control inputs plus register-state outputs.
interface mioc_flop_bank_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             en;
  logic             set;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             sout;
  logic             chg;
  logic             word_vld;
  logic [CW-1:0]    shift_cnt;

  modport master (
    output en, set, mode, d, sin,
    input  q, qb, sout, chg, word_vld, shift_cnt
  );

  modport slave (
    input  en, set, mode, d, sin,
    output q, qb, sout, chg, word_vld, shift_cnt
  );
endinterface

// File: rtl/mioc_flop_bank.sv
// WIDTH-bit MIOC storage bank clocked on the falling edge of in2: hold/load/shift/toggle,
// synchronous preset, change pulse and serial word-complete strobe.
module mioc_flop_bank #(
  parameter int unsigned     WIDTH  = 8,
  parameter logic [WIDTH-1:0] INIT   = '0,
  parameter logic [WIDTH-1:0] PRESET = '1
) (
  input  logic             in2,
  input  logic             in1,
  mioc_flop_bank_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_LOAD   = 2'b01,
    MODE_SHIFT  = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             chg_q, chg_d;
  logic             wv_q, wv_d;

  // Next-state: set beats en; the strobes are cleared on every edge not asserting them.
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    wv_d  = 1'b0;
    if (bus.set) begin
      q_d   = PRESET;
      cnt_d = '0;
    end else if (bus.en) begin
      unique case (mode_e'(bus.mode))
        MODE_HOLD: ;
        MODE_LOAD: begin
          q_d   = bus.d;
          cnt_d = '0;
        end
        MODE_SHIFT: begin
          q_d = {q_q[WIDTH-2:0], bus.sin};
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d = '0;
            wv_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        MODE_TOGGLE: q_d = q_q ^ bus.d;
      endcase
    end
    chg_d = (q_d != q_q);
  end

  always_ff @(negedge in2 or negedge in1) begin
    if (!in1) begin
      q_q   <= INIT;
      cnt_q <= '0;
      chg_q <= 1'b0;
      wv_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      chg_q <= chg_d;
      wv_q  <= wv_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.qb        = ~q_q;
  assign bus.sout      = q_q[WIDTH-1];
  assign bus.chg       = chg_q;
  assign bus.word_vld  = wv_q;
  assign bus.shift_cnt = cnt_q;

endmodule

// File: tb/tb_mioc_flop_bank.sv
// Self-checking bench for mioc_flop_bank: directed scenarios plus random traffic against a
// behavioural model, and a WIDTH=2 / WIDTH=32 sweep.
module tb_mioc_flop_bank;

  localparam logic [1:0]  PAT2  = 2'b10;
  localparam logic [31:0] PAT32 = 32'hAAAA_AAAA;

  logic in2 = 1'b1;
  logic in1 = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 in2 = ~in2;

  mioc_flop_bank_if #(.WIDTH(8))  b8  ();
  mioc_flop_bank_if #(.WIDTH(2))  b2  ();
  mioc_flop_bank_if #(.WIDTH(32)) b32 ();

  mioc_flop_bank #(.WIDTH(8)) u8 (.in2(in2), .in1(in1), .bus(b8));
  mioc_flop_bank #(.WIDTH(2),  .INIT(PAT2),  .PRESET(PAT2))  u2  (.in2(in2), .in1(in1), .bus(b2));
  mioc_flop_bank #(.WIDTH(32), .INIT(PAT32), .PRESET(PAT32)) u32 (.in2(in2), .in1(in1), .bus(b32));

  // Reference state for the 8-bit bank: contents, bits collected in the current word, strobes.
  logic [7:0] m_q;
  int         m_n;
  logic       m_chg, m_wv;

  task automatic model_reset();
    m_q = 8'h00; m_n = 0; m_chg = 1'b0; m_wv = 1'b0;
  endtask

  // Drive one falling-edge transaction on the 8-bit bank, advance the model, sample after the edge.
  task automatic cyc(input logic en, input logic set, input logic [1:0] mode,
                     input logic [7:0] d, input logic sin);
    logic [7:0] old;
    b8.en = en; b8.set = set; b8.mode = mode; b8.d = d; b8.sin = sin;
    old   = m_q;
    m_wv  = 1'b0;
    if (set) begin
      m_q = 8'hFF; m_n = 0;
    end else if (en) begin
      if (mode == 2'd1) begin
        m_q = d; m_n = 0;
      end else if (mode == 2'd2) begin
        m_q = 8'((m_q * 2) + sin);
        m_n = m_n + 1;
        if (m_n == 8) begin m_n = 0; m_wv = 1'b1; end
      end else if (mode == 2'd3) begin
        m_q = m_q ^ d;
      end
    end
    m_chg = (m_q != old);
    @(negedge in2);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 2'd1, 8'hA5, 0);
    checks++; if (b8.q !== 8'hA5) begin failures++; $display("FAIL rst_preload q=%h exp=%h", b8.q, 8'hA5); end
    #2 in1 = 1'b0;
    #1;
    model_reset();
    checks++; if (b8.q !== 8'h00) begin failures++; $display("FAIL rst_q q=%h exp=00", b8.q); end
    checks++; if (b8.qb !== 8'hFF) begin failures++; $display("FAIL rst_qb qb=%h exp=ff", b8.qb); end
    checks++; if (b8.chg !== 1'b0 || b8.word_vld !== 1'b0) begin failures++;
      $display("FAIL rst_strobes chg=%b word_vld=%b exp=0/0", b8.chg, b8.word_vld); end
    checks++; if (b8.shift_cnt !== 3'd0 || b8.sout !== 1'b0) begin failures++;
      $display("FAIL rst_cnt_sout cnt=%0d sout=%b exp=0/0", b8.shift_cnt, b8.sout); end
    #2 in1 = 1'b1;
    cyc(1, 0, 2'd1, 8'h3C, 0);
    checks++; if (b8.q !== 8'h3C || b8.chg !== 1'b1) begin failures++;
      $display("FAIL rst_load q=%h chg=%b exp=3c/1", b8.q, b8.chg); end
    cyc(1, 0, 2'd0, 8'h00, 0);
    checks++; if (b8.chg !== 1'b0) begin failures++; $display("FAIL rst_chg_pulse chg=%b exp=0", b8.chg); end
  endtask

  task automatic test_serial_word();
    logic [7:0] bits;
    bits = 8'b1011_0010;
    cyc(1, 0, 2'd1, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 2'd2, 8'h00, bits[7-i]);
      checks++; if (b8.shift_cnt !== 3'((i + 1) % 8)) begin failures++;
        $display("FAIL serial_cnt step=%0d cnt=%0d exp=%0d", i, b8.shift_cnt, (i + 1) % 8); end
      checks++; if (b8.word_vld !== (i == 7)) begin failures++;
        $display("FAIL serial_wv step=%0d wv=%b exp=%b", i, b8.word_vld, i == 7); end
    end
    checks++; if (b8.q !== 8'hB2 || b8.sout !== 1'b1) begin failures++;
      $display("FAIL serial_word q=%h sout=%b exp=b2/1", b8.q, b8.sout); end
    cyc(1, 0, 2'd0, 8'h00, 0);
    checks++; if (b8.word_vld !== 1'b0) begin failures++; $display("FAIL serial_wv_width wv=%b exp=0", b8.word_vld); end
  endtask

  task automatic test_interrupted();
    cyc(1, 0, 2'd1, 8'h00, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 2'd2, 8'h00, 1'($urandom_range(0, 1)));
    checks++; if (b8.shift_cnt !== 3'd5) begin failures++; $display("FAIL intr_shift cnt=%0d exp=5", b8.shift_cnt); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 2'($urandom_range(0, 3)), 8'($urandom), 0);
      checks++; if (b8.shift_cnt !== 3'd5 || b8.q !== m_q) begin failures++;
        $display("FAIL intr_hold cnt=%0d q=%h exp=5/%h", b8.shift_cnt, b8.q, m_q); end
    end
    cyc(1, 0, 2'd3, 8'h0F, 0);
    checks++; if (b8.shift_cnt !== 3'd5 || b8.q !== m_q) begin failures++;
      $display("FAIL intr_toggle cnt=%0d q=%h exp=5/%h", b8.shift_cnt, b8.q, m_q); end
    cyc(1, 0, 2'd1, 8'h00, 0);
    checks++; if (b8.shift_cnt !== 3'd0) begin failures++; $display("FAIL intr_load cnt=%0d exp=0", b8.shift_cnt); end
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 2'd2, 8'h00, 1'($urandom_range(0, 1)));
      checks++; if (b8.word_vld !== (i == 7)) begin failures++;
        $display("FAIL intr_rewordstep=%0d wv=%b exp=%b", i, b8.word_vld, i == 7); end
    end
  endtask

  task automatic test_toggle_chg();
    cyc(1, 0, 2'd1, 8'h55, 0);
    cyc(1, 0, 2'd3, 8'hFF, 0);
    checks++; if (b8.q !== 8'hAA || b8.chg !== 1'b1) begin failures++;
      $display("FAIL toggle_ff q=%h chg=%b exp=aa/1", b8.q, b8.chg); end
    cyc(1, 0, 2'd3, 8'h00, 0);
    checks++; if (b8.q !== 8'hAA || b8.chg !== 1'b0) begin failures++;
      $display("FAIL toggle_00 q=%h chg=%b exp=aa/0", b8.q, b8.chg); end
  endtask

  task automatic test_set_priority();
    cyc(1, 0, 2'd1, 8'h00, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 2'd2, 8'h00, 1'($urandom_range(0, 1)));
    checks++; if (b8.shift_cnt !== 3'd7) begin failures++; $display("FAIL set_pre cnt=%0d exp=7", b8.shift_cnt); end
    cyc(0, 1, 2'd2, 8'h00, 1);
    checks++; if (b8.q !== 8'hFF || b8.shift_cnt !== 3'd0 || b8.word_vld !== 1'b0) begin failures++;
      $display("FAIL set_en0 q=%h cnt=%0d wv=%b exp=ff/0/0", b8.q, b8.shift_cnt, b8.word_vld); end
    cyc(1, 1, 2'd1, 8'h12, 0);
    checks++; if (b8.q !== 8'hFF || b8.chg !== 1'b0) begin failures++;
      $display("FAIL set_repeat q=%h chg=%b exp=ff/0", b8.q, b8.chg); end
    for (int i = 0; i < 7; i++) cyc(1, 0, 2'd2, 8'h00, 0);
    cyc(1, 1, 2'd2, 8'h00, 0);
    checks++; if (b8.word_vld !== 1'b0 || b8.shift_cnt !== 3'd0 || b8.q !== 8'hFF) begin failures++;
      $display("FAIL set_vs_wrap wv=%b cnt=%0d q=%h exp=0/0/ff", b8.word_vld, b8.shift_cnt, b8.q); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
          2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)));
      checks++; if (b8.q !== m_q || b8.qb !== ~m_q || b8.sout !== m_q[7]) begin failures++;
        $display("FAIL rand_q i=%0d q=%h qb=%h sout=%b exp_q=%h", i, b8.q, b8.qb, b8.sout, m_q); end
      checks++; if (b8.shift_cnt !== 3'(m_n)) begin failures++;
        $display("FAIL rand_cnt i=%0d cnt=%0d exp=%0d", i, b8.shift_cnt, m_n); end
      checks++; if (b8.chg !== m_chg || b8.word_vld !== m_wv) begin failures++;
        $display("FAIL rand_strobes i=%0d chg=%b wv=%b exp=%b/%b", i, b8.chg, b8.word_vld, m_chg, m_wv); end
      if ($urandom_range(0, 49) == 0) begin
        #2 in1 = 1'b0;
        #1;
        model_reset();
        checks++; if (b8.q !== 8'h00 || b8.shift_cnt !== 3'd0 || b8.chg !== 1'b0 || b8.word_vld !== 1'b0) begin
          failures++; $display("FAIL rand_async_rst q=%h cnt=%0d chg=%b wv=%b exp=00/0/0/0",
                               b8.q, b8.shift_cnt, b8.chg, b8.word_vld); end
        #1 in1 = 1'b1;
      end
    end
  endtask

  task automatic test_sweep();
    logic [1:0]  s2;
    logic [31:0] s32;
    int          n2, n32;
    logic        s;
    b8.en = 0; b8.set = 0;
    b2.en = 1; b2.set = 0; b2.mode = 2'd1; b2.d = ~PAT2;
    b32.en = 1; b32.set = 0; b32.mode = 2'd1; b32.d = ~PAT32;
    @(negedge in2); #1;
    checks++; if (b2.q !== ~PAT2 || b32.q !== ~PAT32) begin failures++;
      $display("FAIL sweep_preload q2=%h q32=%h exp=%h/%h", b2.q, b32.q, ~PAT2, ~PAT32); end
    #2 in1 = 1'b0;
    #1;
    model_reset();
    checks++; if (b2.q !== PAT2 || b32.q !== PAT32 || b2.qb !== ~PAT2 || b32.sout !== 1'b1) begin failures++;
      $display("FAIL sweep_init q2=%h q32=%h qb2=%h sout32=%b exp=%h/%h", b2.q, b32.q, b2.qb, b32.sout, PAT2, PAT32); end
    #2 in1 = 1'b1;
    s2 = PAT2; s32 = PAT32; n2 = 0; n32 = 0;
    b2.mode = 2'd2; b32.mode = 2'd2;
    for (int k = 1; k <= 70; k++) begin
      s = 1'($urandom_range(0, 1));
      b2.sin = s; b32.sin = s;
      s2  = 2'((s2 * 2) + s);
      s32 = 32'(({1'b0, s32} * 2) + s);
      @(negedge in2); #1;
      checks++; if (b2.word_vld !== (k % 2 == 0) || b2.q !== s2 || b2.shift_cnt !== 1'((k % 2))) begin failures++;
        $display("FAIL sweep_w2 k=%0d wv=%b q=%h cnt=%0d exp=%b/%h/%0d", k, b2.word_vld, b2.q, b2.shift_cnt,
                 k % 2 == 0, s2, k % 2); end
      checks++; if (b32.word_vld !== (k % 32 == 0) || b32.q !== s32 || b32.shift_cnt !== 5'(k % 32)) begin failures++;
        $display("FAIL sweep_w32 k=%0d wv=%b q=%h cnt=%0d exp=%b/%h/%0d", k, b32.word_vld, b32.q, b32.shift_cnt,
                 k % 32 == 0, s32, k % 32); end
      n2 += 0; n32 += 0;
    end
    b2.en = 0; b32.en = 0;
  endtask

  initial begin
    b8.en = 0; b8.set = 0; b8.mode = 0; b8.d = 0; b8.sin = 0;
    b2.en = 0; b2.set = 0; b2.mode = 0; b2.d = 0; b2.sin = 0;
    b32.en = 0; b32.set = 0; b32.mode = 0; b32.d = 0; b32.sin = 0;
    model_reset();
    @(negedge in2);
    #3 in1 = 1'b1;
    @(negedge in2); #1;
    checks++; if (b8.q !== 8'h00 || b8.chg !== 1'b0 || b8.word_vld !== 1'b0) begin failures++;
      $display("FAIL por_state q=%h chg=%b wv=%b exp=00/0/0", b8.q, b8.chg, b8.word_vld); end
    test_reset();
    test_serial_word();
    test_interrupted();
    test_toggle_chg();
    test_set_priority();
    test_random();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
